// File: rtl/mem_access_ctrl.sv
// Load/store initiator: turns single or block requests into per-cycle byte-lane memory commands.
// Optional build macro ALIGN_CHECK_EN rejects misaligned halfword/word accesses at accept.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned MEM_SIZE = 49
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic [2:0]            op,
  input  logic                  multi,
  input  logic [3:0]            count,
  input  logic [ADDR_W-1:0]     base,
  input  logic [31:0]           wdata,
  output logic                  ready,
  output logic [3:0]            wd_idx,
  output logic [31:0]           rdata,
  output logic                  rd_valid,
  output logic [3:0]            rd_idx,
  output logic                  done,
  output logic                  fault,
  output logic [2:0]            mem_control,
  output logic [4*ADDR_W-1:0]   mem_address,
  output logic [7:0]            mem_dw0,
  output logic [7:0]            mem_dw1,
  output logic [7:0]            mem_dw2,
  output logic [7:0]            mem_dw3,
  input  logic [31:0]           mem_read
);

  localparam logic [2:0] OP_LDRB  = 3'd0;
  localparam logic [2:0] OP_LDRH  = 3'd1;
  localparam logic [2:0] OP_LDR   = 3'd2;
  localparam logic [2:0] OP_LDRSB = 3'd3;
  localparam logic [2:0] OP_LDRSH = 3'd4;
  localparam logic [2:0] OP_STRB  = 3'd5;
  localparam logic [2:0] OP_STRH  = 3'd6;
  localparam logic [2:0] OP_STR   = 3'd7;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic [3:0]        n_q;
  logic [3:0]        idx_q;
  logic [ADDR_W-1:0] addr_q;

  logic              accept_c;
  logic              align_bad_c;
  logic              is_store_c;
  logic              last_c;
  logic              oor_c;
  logic [2:0]        eff_op_c;
  logic [ADDR_W-1:0] lane_c [4];
  logic [3:0]        lane_oor_c;
  logic [31:0]       ext_c;

  // Lane addresses of the current word and the range check over the lanes the op touches
  always_comb begin
    is_store_c = (op_q >= OP_STRB);
    for (int k = 0; k < 4; k++) begin
      lane_c[k]     = addr_q + ADDR_W'(k);
      lane_oor_c[k] = (32'(lane_c[k]) >= MEM_SIZE);
    end
    case (op_q)
      OP_STRB: oor_c = lane_oor_c[0];
      OP_STRH: oor_c = |lane_oor_c[1:0];
      default: oor_c = |lane_oor_c;
    endcase
    last_c = ((5'(idx_q) + 5'd1) >= 5'(n_q));
  end

  // Block transfers collapse to word load/store; alignment is judged on the reduced op
  always_comb begin
    eff_op_c = multi ? ((op < OP_STRB) ? OP_LDR : OP_STR) : op;
`ifdef ALIGN_CHECK_EN
    case (eff_op_c)
      OP_LDRH, OP_LDRSH, OP_STRH: align_bad_c = base[0];
      OP_LDR, OP_STR:             align_bad_c = |base[1:0];
      default:                    align_bad_c = 1'b0;
    endcase
`else
    align_bad_c = 1'b0;
`endif
  end

  // Load data extraction and extension
  always_comb begin
    case (op_q)
      OP_LDRB:  ext_c = {24'd0, mem_read[7:0]};
      OP_LDRSB: ext_c = {{24{mem_read[7]}}, mem_read[7:0]};
      OP_LDRH:  ext_c = {16'd0, mem_read[15:0]};
      OP_LDRSH: ext_c = {{16{mem_read[15]}}, mem_read[15:0]};
      default:  ext_c = mem_read;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Memory commands are decoded straight from state so reset removes them immediately
  always_comb begin
    state_nxt   = state;
    accept_c    = 1'b0;
    ready       = 1'b0;
    done        = 1'b0;
    wd_idx      = 4'd0;
    mem_control = 3'd0;
    mem_address = '0;
    mem_dw0     = 8'd0;
    mem_dw1     = 8'd0;
    mem_dw2     = 8'd0;
    mem_dw3     = 8'd0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          accept_c  = 1'b1;
          state_nxt = ((multi && (count == 4'd0)) || align_bad_c) ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        mem_address = {lane_c[3], lane_c[2], lane_c[1], lane_c[0]};
        wd_idx      = idx_q;
        if (is_store_c) begin
          mem_dw0 = wdata[7:0];
          mem_dw1 = wdata[15:8];
          mem_dw2 = wdata[23:16];
          mem_dw3 = wdata[31:24];
          if (!oor_c) begin
            case (op_q)
              OP_STRB: mem_control = 3'd1;
              OP_STRH: mem_control = 3'd2;
              default: mem_control = 3'd3;
            endcase
          end
        end
        if (oor_c || last_c) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request context, word walk and registered load results
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q     <= OP_LDRB;
      n_q      <= 4'd0;
      idx_q    <= 4'd0;
      addr_q   <= '0;
      rdata    <= 32'd0;
      rd_valid <= 1'b0;
      rd_idx   <= 4'd0;
      fault    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (accept_c) begin
        op_q   <= eff_op_c;
        n_q    <= multi ? count : 4'd1;
        idx_q  <= 4'd0;
        addr_q <= base;
        fault  <= align_bad_c;
      end else if (state == ACCESS) begin
        idx_q  <= idx_q + 4'd1;
        addr_q <= addr_q + ADDR_W'(4);
        if (oor_c) fault <= 1'b1;
        if (!is_store_c) begin
          rd_valid <= 1'b1;
          rd_idx   <= idx_q;
          rdata    <= oor_c ? 32'd0 : ext_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: byte-array memory model, randomized requests,
// expected loads/done pushed at issue and popped by a monitor.
module tb_mem_access_ctrl;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned MEM_SIZE = 49;
  localparam int          AMOD     = 1024;

  logic                clock, reset, req, multi;
  logic [2:0]          op;
  logic [3:0]          count;
  logic [ADDR_W-1:0]   base;
  logic [31:0]         wdata;
  logic                ready, rd_valid, done, fault;
  logic [3:0]          wd_idx, rd_idx;
  logic [31:0]         rdata, mem_read;
  logic [2:0]          mem_control;
  logic [4*ADDR_W-1:0] mem_address;
  logic [7:0]          mem_dw0, mem_dw1, mem_dw2, mem_dw3;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .MEM_SIZE(MEM_SIZE)) dut (
    .clock(clock), .reset(reset), .req(req), .op(op), .multi(multi), .count(count),
    .base(base), .wdata(wdata), .ready(ready), .wd_idx(wd_idx), .rdata(rdata),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .done(done), .fault(fault),
    .mem_control(mem_control), .mem_address(mem_address), .mem_dw0(mem_dw0),
    .mem_dw1(mem_dw1), .mem_dw2(mem_dw2), .mem_dw3(mem_dw3), .mem_read(mem_read)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
  } rd_t;

  rd_t  rdq[$];
  logic doneq[$];

  logic [7:0]        ram     [MEM_SIZE];
  logic [7:0]        ref_mem [MEM_SIZE];
  logic [31:0]       wbuf    [16];
  logic [ADDR_W-1:0] ea      [4];
  logic [7:0]        dwa     [4];
  logic              load_ram;

  logic [63:0] exp_ctrl[$], exp_addr[$];
  logic [63:0] obs_ctrl[64], obs_addr[64], obs_wd[64];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  assign wdata = wbuf[wd_idx];

  // External memory: combinational read, zero if any lane is out of range
  always_comb begin
    for (int k = 0; k < 4; k++) ea[k] = mem_address[k*ADDR_W +: ADDR_W];
    dwa[0] = mem_dw0; dwa[1] = mem_dw1; dwa[2] = mem_dw2; dwa[3] = mem_dw3;
    mem_read = 32'd0;
    if (ea[0] < MEM_SIZE && ea[1] < MEM_SIZE && ea[2] < MEM_SIZE && ea[3] < MEM_SIZE)
      mem_read = {ram[ea[3]], ram[ea[2]], ram[ea[1]], ram[ea[0]]};
  end

  always @(posedge clock) begin
    if (load_ram) begin
      for (int i = 0; i < MEM_SIZE; i++) ram[i] <= ref_mem[i];
    end else if (mem_control != 3'd0) begin
      for (int k = 0; k < 4; k++)
        if ((k < 1 || mem_control >= 3'd2) && (k < 2 || mem_control == 3'd3) && ea[k] < MEM_SIZE)
          ram[ea[k]] <= dwa[k];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents load data or completion
  always @(negedge clock) begin
    if (!reset) begin
      if (rd_valid) begin
        if (rdq.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
        else begin
          rd_t e;
          e = rdq.pop_front();
          chk("rd_idx", 64'(rd_idx), 64'(e.idx));
          chk("rdata", 64'(rdata), 64'(e.data));
        end
      end
      if (done) begin
        if (doneq.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
        else chk("fault_at_done", 64'(fault), 64'(doneq.pop_front()));
      end
    end
  end

  function automatic bit misaligned(input int eo, input logic [9:0] b);
`ifdef ALIGN_CHECK_EN
    if (eo == 1 || eo == 4 || eo == 6) return b[0];
    if (eo == 2 || eo == 7) return (b[1:0] != 2'd0);
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model of one request: expected commands per cycle, load results, fault
  task automatic model(input logic [2:0] o, input logic m, input logic [3:0] c,
                       input logic [9:0] b, output int nacc, output int eo);
    int n, w, nl, la;
    bit flt, bad_l;
    logic [63:0] adr;
    logic [31:0] word, val;
    exp_ctrl.delete();
    exp_addr.delete();
    eo   = m ? ((o < 5) ? 2 : 7) : int'(o);
    n    = m ? int'(c) : 1;
    flt  = 1'b0;
    nacc = 0;
    if (misaligned(eo, b)) begin flt = 1'b1; n = 0; end
    for (int i = 0; i < n; i++) begin
      w     = (int'(b) + 4 * i) % AMOD;
      nl    = (eo == 5) ? 1 : (eo == 6) ? 2 : 4;
      bad_l = 1'b0;
      adr   = 64'd0;
      for (int k = 0; k < 4; k++) adr = adr | (64'((w + k) % AMOD) << (ADDR_W * k));
      for (int k = 0; k < nl; k++) if (((w + k) % AMOD) >= int'(MEM_SIZE)) bad_l = 1'b1;
      nacc++;
      exp_addr.push_back(adr);
      if (eo >= 5) begin
        exp_ctrl.push_back(bad_l ? 64'd0 : 64'(nl == 1 ? 1 : nl == 2 ? 2 : 3));
        if (!bad_l)
          for (int k = 0; k < nl; k++) ref_mem[w + k] = wbuf[i][8*k +: 8];
      end else begin
        exp_ctrl.push_back(64'd0);
        word = 32'd0;
        if (!bad_l)
          for (int k = 0; k < 4; k++) begin la = w + k; word[8*k +: 8] = ref_mem[la]; end
        case (eo)
          0:       val = 32'(word[7:0]);
          1:       val = 32'(word[15:0]);
          3:       val = 32'($signed(word[7:0]));
          4:       val = 32'($signed(word[15:0]));
          default: val = word;
        endcase
        rdq.push_back('{4'(i), val});
      end
      if (bad_l) begin flt = 1'b1; break; end
    end
    doneq.push_back(flt);
  endtask

  task automatic run_req(input logic [2:0] o, input logic m, input logic [3:0] c, input logic [9:0] b);
    int nacc, eo, cyc;
    bit got;
    model(o, m, c, b, nacc, eo);
    @(negedge clock);
    chk("ready_before_req", 64'(ready), 64'd1);
    op = o; multi = m; count = c; base = b; req = 1'b1;
    @(negedge clock);
    req = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (cyc < 40) begin
      if (done) begin got = 1'b1; break; end
      obs_ctrl[cyc] = 64'(mem_control);
      obs_addr[cyc] = 64'(mem_address);
      obs_wd[cyc]   = 64'(wd_idx);
      cyc++;
      @(negedge clock);
    end
    if (!got) begin
      chk("done_timeout", 64'd0, 64'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      rdq.delete();
      doneq.delete();
    end else begin
      chk("access_cycles", 64'(cyc), 64'(nacc));
      for (int i = 0; i < cyc && i < nacc; i++) begin
        chk("mem_control", obs_ctrl[i], exp_ctrl[i]);
        chk("mem_address", obs_addr[i], exp_addr[i]);
        if (eo >= 5) chk("wd_idx", obs_wd[i], 64'(i));
      end
    end
  endtask

  initial begin
    logic [31:0] saved, v;
    logic [9:0] rb;
    reset = 1'b1; req = 1'b0; op = 3'd0; multi = 1'b0; count = 4'd0; base = '0;
    load_ram = 1'b1;
    for (int i = 0; i < 16; i++) wbuf[i] = 32'd0;
    for (int i = 0; i < MEM_SIZE; i++) begin v = $urandom; ref_mem[i] = v[7:0]; end
    @(negedge clock);
    @(negedge clock);
    load_ram = 1'b0;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_mem_control", 64'(mem_control), 64'd0);
    chk("rst_mem_address", 64'(mem_address), 64'd0);
    chk("rst_mem_dw", 64'({mem_dw3, mem_dw2, mem_dw1, mem_dw0}), 64'd0);
    reset = 1'b0;

    wbuf[0] = 32'hDEADBEEF;
    run_req(3'd7, 1'b0, 4'd0, 10'd4);
    chk("str_mem_contents", 64'({ram[7], ram[6], ram[5], ram[4]}), 64'hDEADBEEF);
    run_req(3'd2, 1'b0, 4'd0, 10'd4);
    wbuf[0] = 32'h00000080;
    run_req(3'd5, 1'b0, 4'd0, 10'd10);
    run_req(3'd3, 1'b0, 4'd0, 10'd10);
    run_req(3'd0, 1'b0, 4'd0, 10'd10);
    for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
    run_req(3'd7, 1'b1, 4'd3, 10'd20);
    run_req(3'd0, 1'b1, 4'd3, 10'd20);
    run_req(3'd2, 1'b0, 4'd0, 10'd46);
    run_req(3'd6, 1'b1, 4'd4, 10'd40);
    run_req(3'd1, 1'b0, 4'd0, 10'd3);
    run_req(3'd2, 1'b1, 4'd0, 10'd8);

    // Reset during word 1 of a block store: word 0 lands, word 1 must not
    for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
    saved = {ram[7], ram[6], ram[5], ram[4]};
    @(negedge clock);
    op = 3'd7; multi = 1'b1; count = 4'd4; base = 10'd0; req = 1'b1;
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    chk("rst_mid_pre_ctrl", 64'(mem_control), 64'd3);
    reset = 1'b1;
    #1;
    chk("rst_mid_ctrl", 64'(mem_control), 64'd0);
    chk("rst_mid_ready", 64'(ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_word1", 64'({ram[7], ram[6], ram[5], ram[4]}), 64'(saved));
    chk("rst_mid_word0", 64'({ram[3], ram[2], ram[1], ram[0]}), 64'(wbuf[0]));
    for (int k = 0; k < 4; k++) ref_mem[k] = wbuf[0][8*k +: 8];
    run_req(3'd2, 1'b0, 4'd0, 10'd4);

    for (int r = 0; r < 250; r++) begin
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 10'($urandom_range(1015, 1023));
        1, 2:    rb = 10'($urandom_range(0, 1023));
        default: rb = 10'($urandom_range(0, 60));
      endcase
      run_req(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), rb);
    end

    @(negedge clock);
    @(negedge clock);
    chk("rd_left_in_queue", 64'(rdq.size()), 64'd0);
    chk("done_left_in_queue", 64'(doneq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store initiator that drives the external byte-addressed memory's write/read port on behalf of the CPU datapath. It turns a single request (byte, halfword or word, signed or unsigned) or a block request (1–15 consecutive words, push/pop style) into per-cycle memory commands. For each access it generates the four per-lane byte addresses, the write-lane control code and the store bytes, and it extracts, extends and returns load data. It sits between the execute stage and the memory's data port; instruction fetch is not handled here.

## Interface
- ADDR_W, 10, byte-address width per lane
- MEM_SIZE, 49, number of valid bytes; any lane address ≥ MEM_SIZE is out of range
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req  in  1  request; accepted on a rising edge where req=1 and ready=1
- op  in  3  0 LDRB, 1 LDRH, 2 LDR, 3 LDRSB, 4 LDRSH, 5 STRB, 6 STRH, 7 STR
- multi  in  1  block transfer; op is reduced to load/store word (op<5 → LDR, else STR)
- count  in  4  block word count; ignored when multi=0
- base  in  ADDR_W  start byte address
- wdata  in  32  store data for the current word, consumed combinationally during each store ACCESS cycle
- ready  out  1  state==IDLE
- wd_idx  out  4  index of the word whose store data is required now
- rdata  out  32  extended load data (registered)
- rd_valid  out  1  one-cycle pulse per completed load word
- rd_idx  out  4  word index belonging to rdata
- done  out  1  one-cycle pulse at end of request
- fault  out  1  out-of-range (or misaligned) access detected; valid with done, cleared on next accept
- mem_control  out  3  0 none, 1 write lane 0, 2 write lanes 0–1, 3 write lanes 0–3
- mem_address  out  4*ADDR_W  {A3,A2,A1,A0}
- mem_dw0..mem_dw3  out  8 each  store bytes for lanes 0..3
- mem_read  in  32  {RAM[A3],RAM[A2],RAM[A1],RAM[A0]}; combinational; 0 if any lane is out of range

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE → ACCESS on accept. The following are captured on accept: op, multi, base, and n = multi ? count : 1. fault is cleared. Word index i=0.
- Exception: multi=1 with count=0 goes IDLE → DONE with no memory command.
- Word address: Wi = (base + 4·i) mod 2^ADDR_W. Lanes: Ak = (Wi + k) mod 2^ADDR_W for k=0..3, always driven, including for byte/half ops.
- Store ACCESS cycle:
  - mem_control = 1/2/3 for STRB/STRH/STR.
  - mem_dwk = wdata[8k+7:8k].
  - wd_idx = i.
  - The memory writes at the end of this cycle.
- Load ACCESS cycle:
  - mem_control = 0.
  - At the closing edge, rdata is loaded with:
    - LDRB: zero-extended mem_read[7:0]
    - LDRSB: sign-extended mem_read[7:0]
    - LDRH: zero-extended mem_read[15:0]
    - LDRSH: sign-extended mem_read[15:0]
    - LDR: mem_read
  - rd_valid=1 and rd_idx=i are set for the next cycle.
- Range check, evaluated per word in ACCESS:
  - Loads check all four lanes, because the memory zeroes the whole word otherwise.
  - Stores check only the written lanes (1, 2 or 4).
  - On failure: mem_control forced 0, fault set. A load still pulses rd_valid with rdata=0. The request aborts to DONE after this word.
- After each word: i+1 < n → stay in ACCESS with i+1; otherwise → DONE.
- DONE: done=1 for one cycle, then IDLE.
- Outside ACCESS: mem_control=0, mem_dw*=0, mem_address=0.
- Reset values: state IDLE, ready=1, done=0, rd_valid=0, rdata=0, rd_idx=0, wd_idx=0, fault=0, mem_control=0, mem_address=0, mem_dw*=0.
- Reset mid-request: immediate (asynchronous) return to IDLE. mem_control drops to 0 at once, so no write completes at a later edge.

## Timing
- Accept at edge E0. ACCESS for word i spans cycle E0+i … E0+i+1.
- Single request: ACCESS in cycle 1, DONE in cycle 2 (done=1, plus rd_valid=1 for loads), ready=1 in cycle 3.
- Single request throughput: one request per 3 cycles.
- Block of n words: n ACCESS cycles, then DONE. rd_valid for word n-1 coincides with done.
- Stored data is visible in memory from edge E0+i+1.
- req while ready=0 is ignored (not queued).
- Address arithmetic wraps silently modulo 2^ADDR_W. Wrapped addresses are still range-checked.

## Configuration
- ALIGN_CHECK_EN defined: at accept, a halfword op with base[0]≠0, or a word/block op with base[1:0]≠0, produces no ACCESS. The request goes IDLE → DONE with fault=1, mem_control stays 0, and no rd_valid is generated.
- ALIGN_CHECK_EN undefined: unaligned addresses are issued as-is, using per-lane byte addressing.

## Test plan
- STR, base=4, wdata=0xDEADBEEF → one ACCESS cycle with mem_control=3, mem_address={7,6,5,4}; then LDR at base=4 → rdata=0xDEADBEEF, done and rd_valid together, fault=0.
- STRB, base=10, wdata=0x80 → mem_control=1; then LDRSB at base=10 → rdata=0xFFFFFF80; LDRB at base=10 → rdata=0x00000080.
- Block store multi=1, count=3, base=20 → wd_idx 0,1,2 on consecutive cycles, lane-0 addresses 20, 24, 28; then block load of the same words → rd_idx 0,1,2 with matching data, done on the 3rd rd_valid.
- LDR at base=46 (lane 3 = 49 ≥ MEM_SIZE) → rd_valid with rdata=0, fault=1 at done. Block store count=4 at base=40 → words 0–1 written, word 2 (address 48..51) faults, mem_control=0 for word 2, no ACCESS for word 3, fault=1.
- Block store count=4, reset asserted during word 1's ACCESS cycle → mem_control=0 immediately, ready=1, word 1 location unchanged.
- With ALIGN_CHECK_EN, LDRH at base=3 → no ACCESS cycle, done=1 and fault=1 one cycle after accept, no rd_valid. Without the macro → normal load of RAM[4:3].
